// File: rtl/arith_pkg.sv
// Shared arithmetic helpers: default adder geometry and segment index math.
package arith_pkg;

  localparam int unsigned PCSA_WIDTH = 16;
  localparam int unsigned PCSA_SEG_W = 4;

  // Pipeline depth: one register stage per segment.
  function automatic int unsigned nseg(input int unsigned width, input int unsigned seg_w);
    return width / seg_w;
  endfunction

  function automatic int unsigned seg_lsb(input int unsigned k, input int unsigned seg_w);
    return k * seg_w;
  endfunction

endpackage

// File: rtl/rca_segment.sv
// Combinational W-bit ripple-carry adder used for both carry hypotheses of a segment.
module rca_segment #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic [W-1:0] sum,
  output logic         Cout
);

  logic [W:0] w_c;

  always_comb begin
    w_c    = '0;
    sum    = '0;
    w_c[0] = Cin;
    for (int i = 0; i < W; i++) begin
      sum[i]   = A[i] ^ B[i] ^ w_c[i];
      w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end
    Cout = w_c[W];
  end

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder: one SEG_W-bit segment resolved per register stage,
// valid/ready with full backpressure. Define PCSA_SUB_MODE_EN to add the sub port (A-B).
module pipelined_carry_select_adder
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = PCSA_WIDTH,
  parameter int unsigned SEG_W = PCSA_SEG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef PCSA_SUB_MODE_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             ovf
);

  localparam int unsigned NSEG = nseg(WIDTH, SEG_W);

  // Per-stage record: resolved low sum bits travel with the unconsumed operand bits.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             msb_carry;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t           r_stg [NSEG];
  stage_t           w_src [NSEG];
  stage_t           w_nxt [NSEG];
  logic [NSEG-1:0]  w_valid;
  logic [NSEG-1:0]  w_accept;
  logic [WIDTH-1:0] w_b0;
  logic             w_cin0;

`ifdef PCSA_SUB_MODE_EN
  assign w_b0   = sub ? ~B : B;
  assign w_cin0 = sub | Cin;
`else
  assign w_b0   = B;
  assign w_cin0 = Cin;
`endif

  assign in_ready = w_accept[0];

  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    localparam int unsigned LSB = seg_lsb(k, SEG_W);

    logic [SEG_W-1:0] w_a;
    logic [SEG_W-1:0] w_b;
    logic [SEG_W-1:0] w_s0;
    logic [SEG_W-1:0] w_s1;
    logic [SEG_W-1:0] w_sel;
    logic             w_c0;
    logic             w_c1;
    logic             w_cout;
    logic [WIDTH-1:0] w_sum;

    if (k == 0) begin : g_head
      assign w_src[k] = '{valid: in_valid, sum: '0, carry: w_cin0, msb_carry: 1'b0,
                          a: A, b: w_b0};
    end else begin : g_body
      assign w_src[k] = r_stg[k-1];
    end

    // A stage can load when it is empty or when everything downstream of it moves.
    assign w_valid[k]  = r_stg[k].valid;
    assign w_accept[k] = out_ready | ~(&w_valid[NSEG-1:k]);

    assign w_a = w_src[k].a[LSB +: SEG_W];
    assign w_b = w_src[k].b[LSB +: SEG_W];

    rca_segment #(.W(SEG_W)) u_rca_c0 (
      .A(w_a), .B(w_b), .Cin(1'b0), .sum(w_s0), .Cout(w_c0)
    );

    rca_segment #(.W(SEG_W)) u_rca_c1 (
      .A(w_a), .B(w_b), .Cin(1'b1), .sum(w_s1), .Cout(w_c1)
    );

    assign w_sel  = w_src[k].carry ? w_s1 : w_s0;
    assign w_cout = w_src[k].carry ? w_c1 : w_c0;

    always_comb begin
      w_sum                 = w_src[k].sum;
      w_sum[LSB +: SEG_W]   = w_sel;
    end

    assign w_nxt[k] = '{valid: w_src[k].valid, sum: w_sum, carry: w_cout,
                        msb_carry: w_a[SEG_W-1] ^ w_b[SEG_W-1] ^ w_sel[SEG_W-1],
                        a: w_src[k].a, b: w_src[k].b};

    // Payload only loads with a valid entry, so the output holds the last real result.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_stg[k] <= '0;
      end else if (w_accept[k]) begin
        if (w_src[k].valid) r_stg[k] <= w_nxt[k];
        else                r_stg[k].valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_stg[NSEG-1].valid;
  assign sum       = r_stg[NSEG-1].sum;
  assign Cout      = r_stg[NSEG-1].carry;
  assign ovf       = r_stg[NSEG-1].msb_carry ^ r_stg[NSEG-1].carry;

endmodule

// File: doc/pipelined_carry_select_adder.md
Name: pipelined_carry_select_adder

Overview:
- Parametrised, pipelined carry-select adder; the next generation of the team's 4-bit ripple/carry-select adders.
- Splits a WIDTH-bit add into NSEG = WIDTH/SEG_W segments, with one register stage per segment.
- Streams one operand pair per clock under a valid/ready handshake, with full backpressure.
- Sits in the arithmetic datapath between operand staging registers and the result consumer.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of SEG_W and ≥ SEG_W.
- SEG_W, 4, segment width in bits; NSEG = WIDTH/SEG_W is both pipeline depth and latency.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous, active-high reset.
- in_valid, input, 1, operands presented.
- in_ready, output, 1, stage 0 can accept this cycle.
- A, input, WIDTH, operand A.
- B, input, WIDTH, operand B.
- Cin, input, 1, carry-in.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts the result.
- sum, output, WIDTH, registered sum.
- Cout, output, 1, carry-out of the MSB.
- ovf, output, 1, two's-complement overflow, i.e. carry into MSB XOR Cout.

Behaviour:
- Reset (async, rst=1):
  - all stage valid bits clear;
  - out_valid=0, sum=0, Cout=0, ovf=0;
  - in_ready=1 on the first cycle after release.
- Stage k (0..NSEG-1) operation:
  - Computes segment k (bits k*SEG_W+SEG_W-1 : k*SEG_W) twice, once with carry 0 and once with carry 1, using the rca_segment sub-module.
  - Selects the correct result with the carry registered by stage k-1; stage 0 uses Cin.
  - Registers the selected segment sum, the segment carry-out, the carry into its MSB, the lower sum bits already resolved, and the upper A/B bits not yet consumed (skew registers).
- Latency and throughput:
  - A pair accepted on cycle t (in_valid & in_ready) yields out_valid=1 on cycle t+NSEG, provided there is no backpressure.
  - Sustained throughput: 1 result per clock.
- Handshake, per stage:
  - accept_k = !valid_k | advance_{k+1}, where advance_NSEG = out_ready.
  - Stage k loads from stage k-1 when accept_k; bubbles collapse.
  - in_ready = accept_0.
- Output stability:
  - The last stage drives sum/Cout/ovf/out_valid directly from registers.
  - While out_valid & !out_ready, the outputs hold stable and upstream stages fill, then stall.
- in_valid=0 with in_ready=1: a bubble enters; no result is produced for it.
- Simultaneous accept at stage 0 and drain at the output in the same cycle: both occur, and occupancy is unchanged.
- Wrap-around: the sum is modulo 2^WIDTH; Cout carries the lost bit.
- ovf is computed from the MSB segment's carry-in and carry-out.
- rst asserted mid-stream: all in-flight results are discarded and outputs return to reset values asynchronously; no partial result is ever presented.
- Input timing: inputs are sampled only on accept. A, B and Cin may change freely otherwise.

Optional Feature:
- Macro: PCSA_SUB_MODE_EN.
- When defined:
  - adds input port sub (1 bit), sampled with A/B;
  - when sub=1 the block computes A + ~B + 1, i.e. A−B: B is inverted at stage 0 and the stage-0 carry is forced to 1, with Cin ignored;
  - Cout=1 means no borrow; ovf indicates signed overflow of the subtraction.
- When undefined: no sub port, and the block adds only.

Decomposition:
- Shared package arith_pkg:
  - localparam helpers NSEG and SEG_LSB(k);
  - a typedef for the per-stage pipeline record (valid, partial sum, carry, msb_carry, remaining A/B).
- Natural sub-module: rca_segment, a combinational SEG_W-bit ripple-carry adder.
  - Ports: A, B, Cin, sum, Cout.
  - Instantiated twice per stage, once with Cin tied 0 and once tied 1.

Test Plan:
- Basic add, WIDTH=16: A=0x1234, B=0x4321, Cin=0, out_ready=1 → exactly 4 cycles later: out_valid=1, sum=0x5555, Cout=0, ovf=0.
- Full carry ripple: A=0xFFFF, B=0x0001, Cin=0 → sum=0x0000, Cout=1, ovf=0. Also A=0x7FFF, B=0x0001 → sum=0x8000, ovf=1, Cout=0.
- Exhaustive streaming, WIDTH=4/SEG_W=2: all 512 A/B/Cin combinations back-to-back with in_valid=1 → one result per cycle, in order, each matching A+B+Cin.
- Backpressure: hold out_ready=0 for 6 cycles while streaming 0x0001+0x0001, 0x0002+0x0002, ... → out_valid stays high with sum=0x0002 held stable; in_ready falls after 4 accepted pairs; no loss or duplication after release.
- Reset mid-stream: assert rst while 3 results are in flight → out_valid=0 and sum=0 immediately; after release, the first new pair 0x00FF+0x0001 returns 0x0100 with no stale output.
- With PCSA_SUB_MODE_EN, sub=1: A=0x0005, B=0x0007 → sum=0xFFFE, Cout=0 (borrow), ovf=0. Also A=0x8000, B=0x0001 → sum=0x7FFF, ovf=1.
